// File: rtl/bp_inbuf_sequencer.sv
// bp_inbuf_sequencer
//   DEPTH-entry input buffer with per-entry valid bits. Entries are loaded while
//   idle; a begin_run replays every valid entry in ascending address order over a
//   ready/valid port for NUM_ROUNDS passes, tagging each beat with the run tag and
//   round index, then clears the buffer and returns to idle.
//
// Ports
//   clock, reset          sole clock (rising edge), async active-high reset
//   wr_en/wr_addr/wr_data entry write while idle (also sets the entry's valid bit)
//   clear                 clear all valid bits while idle
//   begin_run, tag_in     start a run while idle, latching the run tag
//   out_valid/out_ready   beat handshake
//   out_data/out_addr     entry data and address at the current pointer
//   out_tag/out_round     latched run tag and current round index
//   busy                  run in progress
//   done                  one-cycle pulse at end of run
//   wr_err                one-cycle pulse: wr_en or clear seen outside idle
module bp_inbuf_sequencer #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned ROUND_W    = 3,
    parameter int unsigned NUM_ROUNDS = 4,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               clear,
    input  logic               begin_run,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [AW-1:0]      out_addr,
    output logic [TAG_W-1:0]   out_tag,
    output logic [ROUND_W-1:0] out_round,
    output logic               busy,
    output logic               done,
    output logic               wr_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [AW-1:0]      LastAddr  = AW'(DEPTH - 1);
    localparam logic [ROUND_W-1:0] LastRound = ROUND_W'(NUM_ROUNDS - 1);

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               done_q, done_d;
    logic               wr_err_q, wr_err_d;
    logic               mem_we;

    // Data storage carries no reset; only valid bits define buffer contents.
    logic [DATA_W-1:0]  mem_q [DEPTH];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        round_d  = round_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        wr_err_d = 1'b0;
        mem_we   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Clear first so a same-cycle write survives for its own entry.
                if (clear) begin
                    valid_d = '0;
                end
                if (wr_en) begin
                    valid_d[wr_addr] = 1'b1;
                    mem_we           = 1'b1;
                end
                if (begin_run) begin
                    tag_d   = tag_in;
                    ptr_d   = '0;
                    round_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                wr_err_d = wr_en | clear;
                // Invalid entries are skipped in one cycle; valid ones wait for a handshake.
                if (!valid_q[ptr_q] || out_ready) begin
                    ptr_d = ptr_q + AW'(1);
                    if (ptr_q == LastAddr) begin
                        if (round_q == LastRound) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            round_d = round_q + ROUND_W'(1);
                        end
                    end
                end
            end
            StDone: begin
                wr_err_d = wr_en | clear;
                valid_d  = '0;
                round_d  = '0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            round_q  <= '0;
            tag_q    <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            round_q  <= round_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign busy      = (state_q == StRun);
    assign out_valid = busy && valid_q[ptr_q];
    // Gated outside a run so the port reads zero after reset despite unreset storage.
    assign out_data  = busy ? mem_q[ptr_q] : '0;
    assign out_addr  = ptr_q;
    assign out_tag   = tag_q;
    assign out_round = round_q;
    assign done      = done_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_bp_inbuf_sequencer.sv
// tb_bp_inbuf_sequencer
//   Directed and randomized stimulus for bp_inbuf_sequencer. A buffer model
//   (data + valid arrays) produces the expected beat list for each run; observed
//   handshakes are compared against it, along with run length, pulses and resets.
module tb_bp_inbuf_sequencer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 64;
    localparam int TAG_W  = 2;
    localparam int ROUNDW = 3;
    localparam int NR     = 4;
    localparam int AW     = 6;
    localparam int FULL_LEN = NR * DEPTH + 1;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [ROUNDW-1:0] rnd;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clear = 1'b0;
    logic              begin_run = 1'b0;
    logic [TAG_W-1:0]  tag_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [AW-1:0]     out_addr;
    logic [TAG_W-1:0]  out_tag;
    logic [ROUNDW-1:0] out_round;
    logic              busy;
    logic              done;
    logic              wr_err;

    always #5 clock = ~clock;

    bp_inbuf_sequencer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .ROUND_W(ROUNDW), .NUM_ROUNDS(NR)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear), .begin_run(begin_run), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_tag(out_tag),
        .out_round(out_round), .busy(busy), .done(done), .wr_err(wr_err)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int run_cyc = 0;

    logic [DATA_W-1:0] mem_m [DEPTH];
    bit                vld_m [DEPTH];
    logic [TAG_W-1:0]  tag_m;
    beat_t             exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {63'd0, obs}, {63'd0, exp});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        run_cyc++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        mem_m[a] = d;
        vld_m[a] = 1'b1;
    endtask

    task automatic clr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        clear_model();
    endtask

    // Issues begin_run (optionally with a same-cycle clear/write) and builds the beat list.
    task automatic start_run(input logic [TAG_W-1:0] t, input bit do_clr, input bit do_wr,
                             input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        beat_t b;
        begin_run = 1'b1; tag_in = t; clear = do_clr; wr_en = do_wr; wr_addr = a; wr_data = d;
        if (do_clr) clear_model();
        if (do_wr) begin
            mem_m[a] = d;
            vld_m[a] = 1'b1;
        end
        tag_m = t;
        exp_q.delete();
        for (int r = 0; r < NR; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_m[i]) begin
                    b.addr = AW'(i);
                    b.rnd  = ROUNDW'(r);
                    b.data = mem_m[i];
                    exp_q.push_back(b);
                end
            end
        end
        tick();
        begin_run = 1'b0; clear = 1'b0; wr_en = 1'b0;
        run_cyc = 1;
        check1("start_busy", busy, 1'b1);
        check("start_addr", 64'(out_addr), 64'd0);
        check1("start_valid", out_valid, vld_m[0]);
    endtask

    task automatic pop_check();
        beat_t e;
        if (exp_q.size() == 0) begin
            check1("extra_beat", out_valid, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check("beat_addr", 64'(out_addr), 64'(e.addr));
            check("beat_round", 64'(out_round), 64'(e.rnd));
            check("beat_tag", 64'(out_tag), 64'(tag_m));
            check("beat_data", out_data, e.data);
        end
    endtask

    // Drains the rest of the run; exp_len>0 also checks the cycle of the done pulse.
    task automatic finish_run(input bit rand_ready, input int exp_len);
        bit                got_done = 1'b0;
        bit                pv = 1'b0;
        logic [DATA_W-1:0] pd = '0;
        for (int k = 0; k < 3000 && !got_done; k++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                check1("run_busy", busy, 1'b1);
                if (pv) begin
                    check1("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, pd);
                end
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (out_valid && out_ready) pop_check();
                pv = out_valid && !out_ready;
                pd = out_data;
                tick();
            end
        end
        check1("done_seen", got_done, 1'b1);
        if (exp_len > 0) check("run_len", 64'(run_cyc), 64'(exp_len));
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check1("done_busy", busy, 1'b0);
        check1("done_oval", out_valid, 1'b0);
        out_ready = 1'b0;
        tick();
        check1("done_single", done, 1'b0);
        clear_model();
    endtask

    initial begin
        logic [DATA_W-1:0] d5;
        clear_model();
        tag_m = '0;

        // Reset state
        #2;
        check1("rst_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_wrerr", wr_err, 1'b0);
        check("rst_data", out_data, 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_round", 64'(out_round), 64'd0);
        tick();
        reset = 1'b0;

        // Two sparse entries, four rounds, always ready
        wr(6'd3, {$urandom, $urandom});
        wr(6'd10, {$urandom, $urandom});
        start_run(2'd2, 1'b0, 1'b0, '0, '0);
        finish_run(1'b0, FULL_LEN);

        // Back-pressure on entry 0
        wr(6'd0, 64'hA5);
        start_run(2'd1, 1'b0, 1'b0, '0, '0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check1("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 64'hA5);
            tick();
        end
        out_ready = 1'b1;
        check1("bp_xfer_valid", out_valid, 1'b1);
        pop_check();
        tick();
        out_ready = 1'b0;
        check("bp_advance", 64'(out_addr), 64'd1);
        finish_run(1'b0, 0);

        // Full buffer, data = index
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 64'(i));
        start_run(2'd3, 1'b0, 1'b0, '0, '0);
        finish_run(1'b0, FULL_LEN);

        // Illegal accesses during a run: write, stray begin_run, then clear
        d5 = {$urandom, $urandom};
        wr(6'd5, d5);
        wr(6'd9, {$urandom, $urandom});
        start_run(2'd1, 1'b0, 1'b0, '0, '0);
        out_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = ~d5; begin_run = 1'b1; tag_in = 2'd2;
        tick();
        wr_en = 1'b0; begin_run = 1'b0;
        check1("ill_wrerr_wr", wr_err, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check1("ill_wrerr_clr", wr_err, 1'b1);
        tick();
        check1("ill_wrerr_end", wr_err, 1'b0);
        check("ill_tag_kept", 64'(out_tag), 64'd1);
        finish_run(1'b1, 0);

        // Clear + write + begin_run in one cycle; then an empty run
        wr(6'd1, {$urandom, $urandom});
        wr(6'd20, {$urandom, $urandom});
        start_run(2'd0, 1'b1, 1'b1, 6'd7, {$urandom, $urandom});
        check("sim_beats", 64'(exp_q.size()), 64'(NR));
        finish_run(1'b1, 0);
        start_run(2'd2, 1'b0, 1'b0, '0, '0);
        finish_run(1'b1, FULL_LEN);

        // Randomized loads and back-pressure
        for (int it = 0; it < 3; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr(6'd2, {$urandom, $urandom});
                clr();
            end
            for (int i = 0; i < 16; i++) begin
                wr(AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
            end
            start_run(TAG_W'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
            finish_run(1'b1, 0);
        end

        // Reset during round 1 aborts the run and empties the buffer
        wr(6'd2, {$urandom, $urandom});
        wr(6'd40, {$urandom, $urandom});
        start_run(2'd3, 1'b0, 1'b0, '0, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 400 && out_round != 3'd1; k++) tick();
        check("mr_round1", 64'(out_round), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check1("mr_busy", busy, 1'b0);
        check1("mr_valid", out_valid, 1'b0);
        check1("mr_done", done, 1'b0);
        check("mr_round", 64'(out_round), 64'd0);
        check("mr_data", out_data, 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        clear_model();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            check1("mr_no_done", done, 1'b0);
            tick();
        end
        start_run(2'd1, 1'b0, 1'b0, '0, '0);
        finish_run(1'b1, FULL_LEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
